maxnet_iter_scheduler: RTL and testbench
========================================

Name: maxnet_iter_scheduler

Overview:
Sequences one shared neuron-update unit (PLU) across N Maxnet neurons, one neuron per PLU operation.
Per iteration: issues each neuron index in turn, writes each result to a shadow buffer, then commits the buffer to the activation register.
Counts positive activations to detect convergence (at most one survivor) and reports the winner index.
Sits between the top-level start/finish handshake and the activation, epsilon and PLU datapath.

Parameters:
N, 4, number of neurons (N >= 2)
IDX_W, 2, width of neuron index, equal to clog2(N)
ITER_W, 8, iteration counter width
MAX_ITER, 255, iteration limit; used only when MAXNET_TIMEOUT_EN is defined

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
start  in  1  level; sampled only in IDLE
plu_done  in  1  PLU result for the issued neuron is ready (1-cycle pulse)
plu_pos  in  1  PLU result > 0; valid only while plu_done=1
start_plu  out  1  1-cycle PLU launch strobe
neuron_idx  out  IDX_W  neuron under update; registered, stable from ISSUE through WAIT
we_prim  out  1  load primary inputs into activation register
eps_reg_we  out  1  load epsilon register
we_shadow  out  1  write PLU result to shadow[neuron_idx]
we_a_reg  out  1  commit shadow buffer to activation register
busy  out  1  high in every state except IDLE
finish  out  1  1-cycle completion pulse
winner  out  IDX_W  index of the surviving neuron
win_valid  out  1  exactly one positive activation at convergence
timeout  out  1  run ended on MAX_ITER
iter_cnt  out  ITER_W  number of committed iterations

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; internal idx, pos_cnt and last_pos cleared. Reset during any state aborts the run and issues no further strobes.
- States: IDLE, LOAD, ISSUE, WAIT, COMMIT, CHECK, DONE.
- IDLE: when start=1, go to LOAD. start is ignored in every other state.
- LOAD (1 cycle): we_prim=1, eps_reg_we=1. Clears idx, iter_cnt, pos_cnt, winner, win_valid, timeout. Go to ISSUE.
- ISSUE (1 cycle): start_plu=1, neuron_idx=idx. Go to WAIT.
- WAIT: hold until plu_done=1. No timeout on the PLU; start_plu is never re-issued.
- On plu_done (WAIT): we_shadow=1 in the same cycle (Mealy output). If plu_pos=1, pos_cnt += 1 (saturating at 2) and last_pos <= idx.
- After plu_done in WAIT: if idx==N-1, go to COMMIT; otherwise idx += 1 and go to ISSUE.
- COMMIT (1 cycle): we_a_reg=1, iter_cnt += 1 (saturating at all-ones). Go to CHECK.
- CHECK (1 cycle):
  - If pos_cnt <= 1: win_valid <= (pos_cnt==1), winner <= last_pos (0 if none). Go to DONE.
  - Else if timeout is active and iter_cnt==MAX_ITER: timeout <= 1, win_valid <= 0. Go to DONE.
  - Otherwise: pos_cnt <= 0, idx <= 0. Go to ISSUE.
- DONE (1 cycle): finish=1. Go to IDLE. winner, win_valid, timeout and iter_cnt hold until the next LOAD.
- Strobes: start_plu, we_prim, eps_reg_we, we_a_reg and finish are Moore outputs, decoded from state only.
- Latency: with plu_done one cycle after start_plu, each neuron takes 2 cycles and each iteration takes 2N+2 cycles. LOAD adds 1 cycle and DONE adds 1 cycle.
- Undefined state encodings return to IDLE with all outputs 0.

Optional Feature:
MAXNET_TIMEOUT_EN
- Defined: the iteration limit is active in CHECK and timeout can assert.
- Undefined: iteration continues until convergence; timeout is tied to 0; MAX_ITER is unused.

Test Plan:
- Reset: drive rst=0 mid-simulation -> all outputs 0 immediately; state IDLE; busy=0.
- Nominal run (N=4, plu_done 1 cycle after each start_plu, plu_pos iteration 1 = {1,1,0,1}, iteration 2 = {0,0,0,1}) -> 8 start_plu pulses with neuron_idx 0,1,2,3,0,1,2,3; 8 we_shadow; 2 we_a_reg; finish in cycle 22 (LOAD counted as cycle 1); winner=3, win_valid=1, iter_cnt=2.
- All-zero (plu_pos=0 for all four neurons) -> finish after 1 iteration; win_valid=0, winner=0, iter_cnt=1, timeout=0.
- Timeout (MAXNET_TIMEOUT_EN defined, MAX_ITER=3, plu_pos always 1) -> 3 we_a_reg; finish; timeout=1, win_valid=0, iter_cnt=3. Same stimulus with the macro undefined -> the 4th iteration is issued and no finish occurs.
- PLU stall plus start while busy: hold plu_done=0 for 10 cycles in WAIT and pulse start during the stall -> single start_plu pulse, neuron_idx stable, no state change; run then completes normally.
- Reset in WAIT: rst=0 while idx=2, then restart -> no commit from the aborted run; new run begins with we_prim and neuron_idx=0.

Source files
------------

// File: rtl/maxnet_iter_scheduler_if.sv
// maxnet_iter_scheduler_if
//   Groups the control handshake between the Maxnet scheduler and its
//   surroundings: the start/finish handshake, the PLU launch/return pair,
//   the datapath write enables, and the convergence result.
//
//   Modports:
//     master - environment side: drives start, plu_done, plu_pos and
//              observes everything else.
//     slave  - scheduler side: consumes start, plu_done, plu_pos and
//              drives the strobes, the neuron index and the result fields.
//
//   Signals:
//     start       level request, honoured only while idle
//     plu_done    1-cycle pulse, PLU result for the issued neuron is ready
//     plu_pos     PLU result > 0, valid only with plu_done
//     start_plu   1-cycle PLU launch strobe
//     neuron_idx  neuron under update
//     we_prim     load primary inputs into the activation register
//     eps_reg_we  load the epsilon register
//     we_shadow   write the PLU result into shadow[neuron_idx]
//     we_a_reg    commit the shadow buffer to the activation register
//     busy        high whenever the scheduler is not idle
//     finish      1-cycle completion pulse
//     winner      index of the surviving neuron
//     win_valid   exactly one positive activation at convergence
//     timeout     run ended on the iteration limit
//     iter_cnt    number of committed iterations
interface maxnet_iter_scheduler_if #(
  parameter int IDX_W  = 2,
  parameter int ITER_W = 8
);
  logic              start;
  logic              plu_done;
  logic              plu_pos;
  logic              start_plu;
  logic [IDX_W-1:0]  neuron_idx;
  logic              we_prim;
  logic              eps_reg_we;
  logic              we_shadow;
  logic              we_a_reg;
  logic              busy;
  logic              finish;
  logic [IDX_W-1:0]  winner;
  logic              win_valid;
  logic              timeout;
  logic [ITER_W-1:0] iter_cnt;

  modport master (
    output start, plu_done, plu_pos,
    input  start_plu, neuron_idx, we_prim, eps_reg_we, we_shadow, we_a_reg,
    input  busy, finish, winner, win_valid, timeout, iter_cnt
  );

  modport slave (
    input  start, plu_done, plu_pos,
    output start_plu, neuron_idx, we_prim, eps_reg_we, we_shadow, we_a_reg,
    output busy, finish, winner, win_valid, timeout, iter_cnt
  );
endinterface

// File: rtl/maxnet_iter_scheduler.sv
// maxnet_iter_scheduler
//   Time-multiplexes one shared neuron-update unit (PLU) across N Maxnet
//   neurons. Each iteration launches the PLU once per neuron in index
//   order, writes every result to a shadow buffer, then commits the buffer
//   to the activation register. Positive results are counted (saturating
//   at 2) so that convergence - at most one surviving neuron - can be
//   detected and the winner index reported.
//
//   Ports:
//     i_clk    rising-edge clock
//     i_rst_n  asynchronous active-low reset; aborts any run in progress
//     bus      maxnet_iter_scheduler_if.slave (handshake, strobes, result)
//
//   Optional feature macro: MAXNET_TIMEOUT_EN
//     defined   - a run that has not converged after MAX_ITER committed
//                 iterations ends with timeout=1.
//     undefined - iteration continues until convergence; timeout stays 0.
module maxnet_iter_scheduler #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  maxnet_iter_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_COMMIT = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Elaboration-time guard against inconsistent parameters.
  if (N < 2 || IDX_W != $clog2(N) || MAX_ITER < 1) begin : g_bad_params
    $error("maxnet_iter_scheduler: illegal N/IDX_W/MAX_ITER combination");
  end

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_last_pos;
  logic [IDX_W-1:0]  r_winner;
  logic [1:0]        r_pos_cnt;
  logic [ITER_W-1:0] r_iter_cnt;
  logic              r_win_valid;
  logic              r_timeout;

  logic w_start_plu;
  logic w_we_prim;
  logic w_eps_we;
  logic w_we_shadow;
  logic w_we_a_reg;
  logic w_finish;
  logic w_busy;
  logic w_limit_hit;

`ifdef MAXNET_TIMEOUT_EN
  // iter_cnt already includes the iteration just committed when CHECK runs.
  assign w_limit_hit = (r_iter_cnt == ITER_W'(MAX_ITER));
`else
  assign w_limit_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and strobe decode. Only we_shadow looks at an input (Mealy);
  // the rest depend on the state alone. Unused encodings fall to IDLE
  // with every strobe low.
  always_comb begin
    w_next      = r_state;
    w_start_plu = 1'b0;
    w_we_prim   = 1'b0;
    w_eps_we    = 1'b0;
    w_we_shadow = 1'b0;
    w_we_a_reg  = 1'b0;
    w_finish    = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_busy    = 1'b1;
        w_we_prim = 1'b1;
        w_eps_we  = 1'b1;
        w_next    = S_ISSUE;
      end
      S_ISSUE: begin
        w_busy      = 1'b1;
        w_start_plu = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (bus.plu_done) begin
          w_we_shadow = 1'b1;
          w_next      = (r_idx == LAST_IDX) ? S_COMMIT : S_ISSUE;
        end
      end
      S_COMMIT: begin
        w_busy     = 1'b1;
        w_we_a_reg = 1'b1;
        w_next     = S_CHECK;
      end
      S_CHECK: begin
        w_busy = 1'b1;
        if (r_pos_cnt <= 2'd1 || w_limit_hit) w_next = S_DONE;
        else                                  w_next = S_ISSUE;
      end
      S_DONE: begin
        w_busy   = 1'b1;
        w_finish = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Neuron index, positive-result tally and result registers. The result
  // fields survive DONE and IDLE and are only cleared by the next LOAD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx       <= '0;
      r_last_pos  <= '0;
      r_winner    <= '0;
      r_pos_cnt   <= '0;
      r_iter_cnt  <= '0;
      r_win_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_idx       <= '0;
          r_pos_cnt   <= '0;
          r_iter_cnt  <= '0;
          r_winner    <= '0;
          r_win_valid <= 1'b0;
          r_timeout   <= 1'b0;
        end
        S_WAIT: begin
          if (bus.plu_done) begin
            if (bus.plu_pos) begin
              // Two positives already rule out convergence, so stop at 2.
              if (r_pos_cnt != 2'd2) r_pos_cnt <= r_pos_cnt + 2'd1;
              r_last_pos <= r_idx;
            end
            if (r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_COMMIT: begin
          if (r_iter_cnt != '1) r_iter_cnt <= r_iter_cnt + ITER_W'(1);
        end
        S_CHECK: begin
          if (r_pos_cnt <= 2'd1) begin
            // last_pos is not cleared between iterations, so only trust it
            // when this iteration produced exactly one positive.
            r_win_valid <= (r_pos_cnt == 2'd1);
            r_winner    <= (r_pos_cnt == 2'd1) ? r_last_pos : '0;
          end else if (w_limit_hit) begin
            r_timeout   <= 1'b1;
            r_win_valid <= 1'b0;
          end else begin
            r_pos_cnt <= '0;
            r_idx     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_plu  = w_start_plu;
  assign bus.neuron_idx = r_idx;
  assign bus.we_prim    = w_we_prim;
  assign bus.eps_reg_we = w_eps_we;
  assign bus.we_shadow  = w_we_shadow;
  assign bus.we_a_reg   = w_we_a_reg;
  assign bus.busy       = w_busy;
  assign bus.finish     = w_finish;
  assign bus.winner     = r_winner;
  assign bus.win_valid  = r_win_valid;
  assign bus.timeout    = r_timeout;
  assign bus.iter_cnt   = r_iter_cnt;

endmodule

// File: tb/tb_maxnet_iter_scheduler.sv
// tb_maxnet_iter_scheduler
//   Self-checking bench for maxnet_iter_scheduler. A PLU stand-in answers
//   each start_plu after a per-neuron delay with a sign taken from a table
//   of iterations; a reference model walks the same table and predicts
//   iteration count, winner, timeout and completion cycle.
//   Honours MAXNET_TIMEOUT_EN the same way the design does.
module tb_maxnet_iter_scheduler;

  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int ITER_W   = 8;
  localparam int MAX_ITER = 3;
  localparam int MAXROWS  = 16;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  maxnet_iter_scheduler_if #(.IDX_W(IDX_W), .ITER_W(ITER_W)) bus ();

  maxnet_iter_scheduler #(
    .N(N), .IDX_W(IDX_W), .ITER_W(ITER_W), .MAX_ITER(MAX_ITER)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .bus    (bus.slave)
  );

  int nChecks = 0;
  int nErrors = 0;

  // Per-iteration PLU answers and response delays (cycles after start_plu).
  bit posTab [MAXROWS][N];
  int dlyTab [MAXROWS][N];

  // Observations gathered by applyStimulus.
  int rFinished, rFinCyc, rIssue, rShadow, rCommit, rPrim, rBusyLow, rFirstPrim;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every output must read zero while reset is applied.
  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"},      bus.busy,       0);
    checkOutput({tag, "_start_plu"}, bus.start_plu,  0);
    checkOutput({tag, "_we_prim"},   bus.we_prim,    0);
    checkOutput({tag, "_eps_we"},    bus.eps_reg_we, 0);
    checkOutput({tag, "_we_shadow"}, bus.we_shadow,  0);
    checkOutput({tag, "_we_a_reg"},  bus.we_a_reg,   0);
    checkOutput({tag, "_finish"},    bus.finish,     0);
    checkOutput({tag, "_idx"},       bus.neuron_idx, 0);
    checkOutput({tag, "_winner"},    bus.winner,     0);
    checkOutput({tag, "_win_valid"}, bus.win_valid,  0);
    checkOutput({tag, "_timeout"},   bus.timeout,    0);
    checkOutput({tag, "_iter_cnt"},  bus.iter_cnt,   0);
  endtask

  // All answers negative, every PLU answers after one cycle.
  task automatic clearTables();
    for (int r = 0; r < MAXROWS; r++)
      for (int j = 0; j < N; j++) begin
        posTab[r][j] = 1'b0;
        dlyTab[r][j] = 1;
      end
  endtask

  // Bit j of bits is the sign returned for neuron j.
  task automatic setRow(input int r, input logic [N-1:0] bits);
    for (int j = 0; j < N; j++) posTab[r][j] = bits[j];
  endtask

  // Reference model: Maxnet stops on the first iteration with at most one
  // positive neuron (or at the limit), each neuron costs one issue cycle
  // plus its PLU delay, each iteration adds commit and check, plus LOAD
  // and DONE around the run.
  task automatic modelRun(output int iters, output int winner, output int valid,
                          output int tmo, output int cycles, output int fin);
    int cnt, last;
    iters = 0; winner = 0; valid = 0; tmo = 0; cycles = 1; fin = 0;
    while (!fin && iters < MAXROWS) begin
      cnt = 0; last = 0;
      for (int j = 0; j < N; j++) begin
        cycles += 1 + dlyTab[iters][j];
        if (posTab[iters][j]) begin cnt++; last = j; end
      end
      cycles += 2;
      iters++;
      if (cnt <= 1) begin
        fin = 1; valid = (cnt == 1); winner = (cnt == 1) ? last : 0;
      end
`ifdef MAXNET_TIMEOUT_EN
      else if (iters == MAX_ITER) begin
        fin = 1; tmo = 1;
      end
`endif
    end
    cycles += 1;
  endtask

  // Raises start, then plays the PLU cycle by cycle until finish, the
  // budget runs out, or abortAfter launches have been seen (0 = never).
  // Optionally pulses start in the middle of a long PLU stall.
  task automatic applyStimulus(input int budget, input bit stallStart, input int abortAfter);
    int cyc, cd, k, row, col;
    bit done;
    cyc = 0; cd = 0; k = 0; done = 0; row = 0; col = 0;
    rFinished = 0; rFinCyc = 0; rIssue = 0; rShadow = 0; rCommit = 0;
    rPrim = 0; rBusyLow = 0; rFirstPrim = 0;
    bus.start = 1'b1;
    while (!done && cyc < budget && !(abortAfter > 0 && k >= abortAfter)) begin
      @(posedge clk); #1;
      cyc++;
      bus.start    = 1'b0;
      bus.plu_done = 1'b0;
      bus.plu_pos  = 1'b0;
      if (bus.we_prim) rPrim++;
      if (cyc == 1) rFirstPrim = bus.we_prim;
      if (bus.we_a_reg) rCommit++;
      if (!bus.busy) rBusyLow++;
      if (bus.finish) begin done = 1; rFinCyc = cyc; end
      if (cd > 0) begin
        cd--;
        if (stallStart && cd == 4) bus.start = 1'b1;
        if (cd == 0) begin
          checkOutput("idx_at_done", bus.neuron_idx, col);
          bus.plu_done = 1'b1;
          bus.plu_pos  = (row < MAXROWS) ? posTab[row][col] : 1'b0;
        end
      end
      if (bus.start_plu) begin
        row = k / N; col = k % N;
        checkOutput("issue_idx", bus.neuron_idx, col);
        cd = (row < MAXROWS) ? dlyTab[row][col] : 1;
        k++;
      end
      #1;
      if (bus.we_shadow) rShadow++;
    end
    bus.plu_done = 1'b0;
    bus.plu_pos  = 1'b0;
    bus.start    = 1'b0;
    rIssue = k;
    rFinished = done;
  endtask

  // Full run against the model, then one idle cycle to see results hold.
  task automatic runAndCheck(input string tag, input bit stallStart);
    int eIt, eWin, eVal, eTmo, eCyc, eFin;
    modelRun(eIt, eWin, eVal, eTmo, eCyc, eFin);
    applyStimulus(eCyc + 20, stallStart, 0);
    checkOutput({tag, "_finished"},   rFinished,     eFin);
    checkOutput({tag, "_fin_cycle"},  rFinCyc,       eCyc);
    checkOutput({tag, "_start_plu"},  rIssue,        eIt * N);
    checkOutput({tag, "_we_shadow"},  rShadow,       eIt * N);
    checkOutput({tag, "_we_a_reg"},   rCommit,       eIt);
    checkOutput({tag, "_we_prim"},    rPrim,         1);
    checkOutput({tag, "_first_prim"}, rFirstPrim,    1);
    checkOutput({tag, "_busy_gaps"},  rBusyLow,      0);
    checkOutput({tag, "_winner"},     bus.winner,    eWin);
    checkOutput({tag, "_win_valid"},  bus.win_valid, eVal);
    checkOutput({tag, "_timeout"},    bus.timeout,   eTmo);
    checkOutput({tag, "_iter_cnt"},   bus.iter_cnt,  eIt);
    @(posedge clk); #1;
    checkOutput({tag, "_idle_busy"},   bus.busy,      0);
    checkOutput({tag, "_idle_finish"}, bus.finish,    0);
    checkOutput({tag, "_hold_winner"}, bus.winner,    eWin);
    checkOutput({tag, "_hold_valid"},  bus.win_valid, eVal);
    checkOutput({tag, "_hold_iter"},   bus.iter_cnt,  eIt);
  endtask

  // Directed scenarios first, then randomized runs.
  initial begin
    int planned, mode, quietA, quietP;
    bus.start = 1'b0; bus.plu_done = 1'b0; bus.plu_pos = 1'b0;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("por");
    rstN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] nominal run");
    clearTables();
    setRow(0, 4'b1011);
    setRow(1, 4'b1000);
    runAndCheck("nom", 1'b0);
    checkOutput("nom_cycle22", rFinCyc, 22);

    $display("[TB] all-zero run");
    clearTables();
    runAndCheck("zero", 1'b0);

    $display("[TB] stall with start pulse");
    clearTables();
    setRow(0, 4'b1101);
    setRow(1, 4'b0010);
    dlyTab[0][1] = 10;
    runAndCheck("stall", 1'b1);

    $display("[TB] always-positive run");
    clearTables();
    for (int r = 0; r < MAXROWS; r++) setRow(r, 4'b1111);
`ifdef MAXNET_TIMEOUT_EN
    runAndCheck("tmo", 1'b0);
`else
    applyStimulus(1 + 4 * (2 * N + 2) + 3, 1'b0, 0);
    checkOutput("notmo_finished", rFinished, 0);
    checkOutput("notmo_4th_iter", (rIssue > 3 * N) ? 1 : 0, 1);
    checkOutput("notmo_we_a_reg", rCommit, 4);
    checkOutput("notmo_busy", bus.busy, 1);
    rstN = 1'b0; #1;
    checkReset("notmo_rst");
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
`endif

    $display("[TB] reset while waiting on neuron 2");
    clearTables();
    for (int r = 0; r < MAXROWS; r++) setRow(r, 4'b1111);
    applyStimulus(100, 1'b0, 3);
    @(posedge clk); #1;
    checkOutput("rw_idx_before", bus.neuron_idx, 2);
    checkOutput("rw_busy_before", bus.busy, 1);
    rstN = 1'b0; #1;
    checkReset("rw");
    @(posedge clk); #1;
    rstN = 1'b1;
    quietA = 0; quietP = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.we_a_reg) quietA++;
      if (bus.start_plu) quietP++;
    end
    checkOutput("rw_no_commit", quietA, 0);
    checkOutput("rw_no_issue", quietP, 0);
    clearTables();
    setRow(0, 4'b1011);
    setRow(1, 4'b1000);
    runAndCheck("rw_rerun", 1'b0);

    $display("[TB] randomized runs");
    for (int t = 0; t < 8; t++) begin
      clearTables();
      planned = $urandom_range(1, 4);
      for (int r = 0; r < planned - 1; r++)
        for (int j = 0; j < N; j++) posTab[r][j] = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, N);
      if (mode < N) posTab[planned - 1][mode] = 1'b1;
      for (int r = 0; r < MAXROWS; r++)
        for (int j = 0; j < N; j++) dlyTab[r][j] = $urandom_range(1, 3);
      runAndCheck($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
